rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin write-back arbiter feeding multi-port register-file RAM write ports
//
// Collects write-back requests from N_SRC execution units into one-entry
// holding registers and issues up to W_PORTS RAM writes per cycle, never
// two to the same address in one cycle. Address-0 writes are dropped.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_src_valid  per-source request valid
//   i_src_addr   per-source destination address
//   i_src_data   per-source write data
//   o_src_ready  per-source: holding register can accept this cycle
//   o_w_e        per-port RAM write enable
//   o_w_addr     per-port RAM write address
//   o_w_data     per-port RAM write data
//   o_busy       any holding register valid
module rf_write_arbiter #(
   parameter int N_SRC   = 4,
   parameter int W_PORTS = 2,
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 32,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [N_SRC-1:0]                i_src_valid,
   input  logic [N_SRC-1:0][AW-1:0]        i_src_addr,
   input  logic [N_SRC-1:0][WIDTH-1:0]     i_src_data,
   output logic [N_SRC-1:0]                o_src_ready,
   output logic [W_PORTS-1:0]              o_w_e,
   output logic [W_PORTS-1:0][AW-1:0]      o_w_addr,
   output logic [W_PORTS-1:0][WIDTH-1:0]   o_w_data,
   output logic                            o_busy
);

   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0]            hold_v_q, hold_v_d;
   logic [N_SRC-1:0][AW-1:0]    hold_addr_q, hold_addr_d;
   logic [N_SRC-1:0][WIDTH-1:0] hold_data_q, hold_data_d;
   logic [PW-1:0]               rr_ptr_q, rr_ptr_d;

   logic [N_SRC-1:0]            grant;
   logic [PW:0]                 scan_sum;
   logic [PW-1:0]               scan_idx;
   logic [PW-1:0]               last_src;
   logic                        conflict;
   int                          n_used;

   // Grant scan: built purely from holding-register state so no input
   // reaches the write ports combinationally.
   always_comb begin
      grant    = '0;
      o_w_e    = '0;
      o_w_addr = '0;
      o_w_data = '0;
      rr_ptr_d = rr_ptr_q;
      scan_sum = '0;
      scan_idx = '0;
      last_src = '0;
      conflict = 1'b0;
      n_used   = 0;
      for (int k = 0; k < N_SRC; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (scan_sum >= (PW+1)'(N_SRC)) begin
            scan_sum = scan_sum - (PW+1)'(N_SRC);
         end
         scan_idx = scan_sum[PW-1:0];
         // Only port-granted entries can collide; dropped entries are address 0
         // and a nonzero address never matches them.
         conflict = 1'b0;
         for (int p = 0; p < W_PORTS; p++) begin
            if (p < n_used && o_w_addr[p] == hold_addr_q[scan_idx]) begin
               conflict = 1'b1;
            end
         end
         if (hold_v_q[scan_idx]) begin
            if (hold_addr_q[scan_idx] == '0) begin
               grant[scan_idx] = 1'b1;
            end else if (n_used < W_PORTS && !conflict) begin
               grant[scan_idx] = 1'b1;
               for (int p = 0; p < W_PORTS; p++) begin
                  if (p == n_used) begin
                     o_w_e[p]    = 1'b1;
                     o_w_addr[p] = hold_addr_q[scan_idx];
                     o_w_data[p] = hold_data_q[scan_idx];
                  end
               end
               n_used   = n_used + 1;
               last_src = scan_idx;
            end
         end
      end
      // Rotation resumes just past the last source that actually wrote.
      if (n_used > 0) begin
         rr_ptr_d = (last_src == PW'(N_SRC-1)) ? '0 : last_src + 1'b1;
      end
   end

   // A granted entry frees its slot in the same cycle, so a source can
   // stream one write per cycle.
   assign o_src_ready = ~hold_v_q | grant;
   assign o_busy      = |hold_v_q;

   always_comb begin
      hold_v_d    = hold_v_q & ~grant;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      for (int s = 0; s < N_SRC; s++) begin
         if (i_src_valid[s] && o_src_ready[s]) begin
            hold_v_d[s]    = 1'b1;
            hold_addr_d[s] = i_src_addr[s];
            hold_data_d[s] = i_src_data[s];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold_v_q <= '0;
         rr_ptr_q <= '0;
      end else begin
         hold_v_q <= hold_v_d;
         rr_ptr_q <= rr_ptr_d;
      end
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter against a queue-based reference model
module tb_rf_write_arbiter;

   localparam int N     = 4;
   localparam int WP    = 2;
   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   typedef struct {
      int              cyc;
      int              port;
      logic [AW-1:0]   addr;
      logic [WIDTH-1:0] data;
   } wr_t;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [N-1:0]                 src_valid;
   logic [N-1:0][AW-1:0]         src_addr;
   logic [N-1:0][WIDTH-1:0]      src_data;
   logic [N-1:0]                 src_ready;
   logic [WP-1:0]                w_e;
   logic [WP-1:0][AW-1:0]        w_addr;
   logic [WP-1:0][WIDTH-1:0]     w_data;
   logic                         busy;

   rf_write_arbiter #(.N_SRC(N), .W_PORTS(WP), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_src_valid (src_valid),
      .i_src_addr  (src_addr),
      .i_src_data  (src_data),
      .o_src_ready (src_ready),
      .o_w_e       (w_e),
      .o_w_addr    (w_addr),
      .o_w_data    (w_data),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   wr_t exp_q[$];

   // reference model state: what each source's slot holds, and where the scan starts
   logic [N-1:0]     mv;
   logic [AW-1:0]    ma [N];
   logic [WIDTH-1:0] md [N];
   int               mrr;

   logic [AW-1:0]    st_addr [N];
   logic [WIDTH-1:0] st_data [N];

   int fair_lo = 1000000000;
   int fair_hi = 0;
   int fcnt  [N];
   int fwait [N];
   int fmax  [N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end else begin
         passes++;
      end
   endtask

   // One clock of stimulus: predict this cycle's writes from the model,
   // check handshake outputs, drive new inputs, then advance the model.
   task automatic step(input logic r, input logic [N-1:0] v);
      logic [N-1:0]  gr;
      logic [N-1:0]  rdy;
      logic [AW-1:0] used[$];
      int            np, last, s;
      bit            conf;
      @(negedge clk);
      cyc++;
      gr = '0; np = 0; last = 0;
      used.delete();
      for (int k = 0; k < N; k++) begin
         s = (mrr + k) % N;
         if (mv[s]) begin
            if (ma[s] == '0) begin
               gr[s] = 1'b1;
            end else begin
               conf = 0;
               foreach (used[i]) if (used[i] == ma[s]) conf = 1;
               if (np < WP && !conf) begin
                  gr[s] = 1'b1;
                  exp_q.push_back('{cyc, np, ma[s], md[s]});
                  used.push_back(ma[s]);
                  np++;
                  last = s;
               end
            end
         end
      end
      rdy = ~mv | gr;
      chk("src_ready", 64'(src_ready), 64'(rdy));
      chk("busy", 64'(busy), 64'(|mv));
      rst       = r;
      src_valid = v;
      for (int i = 0; i < N; i++) begin
         src_addr[i] = st_addr[i];
         src_data[i] = st_data[i];
      end
      if (r) begin
         mv  = '0;
         mrr = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (gr[i]) mv[i] = 1'b0;
            if (v[i] && rdy[i]) begin
               mv[i] = 1'b1;
               ma[i] = st_addr[i];
               md[i] = st_data[i];
            end
         end
         if (np > 0) mrr = (last + 1) % N;
      end
   endtask

   // Monitor: every asserted write port must match the next expected write.
   initial begin
      logic [N-1:0] gmask;
      wr_t e;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            $display("FAIL missing_write: expected addr %0h data %0h in cycle %0d, not issued",
                     exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         gmask = '0;
         for (int p = 0; p < WP; p++) begin
            if (w_e[p]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_write cycle %0d: port %0d addr %0h data %0h, expected none",
                           cyc, p, w_addr[p], w_data[p]);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                  chk("wr_port", 64'(p), 64'(e.port));
                  chk("wr_addr", 64'(w_addr[p]), 64'(e.addr));
                  chk("wr_data", 64'(w_data[p]), 64'(e.data));
               end
               if (w_addr[p] >= 1 && w_addr[p] <= N) gmask[w_addr[p]-1] = 1'b1;
            end
         end
         if (cyc >= fair_lo && cyc <= fair_hi) begin
            for (int s = 0; s < N; s++) begin
               if (gmask[s]) begin
                  fcnt[s]++;
                  fwait[s] = 0;
               end else begin
                  fwait[s]++;
                  if (fwait[s] > fmax[s]) fmax[s] = fwait[s];
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_src(input int s, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      st_addr[s] = a;
      st_data[s] = d;
   endtask

   task automatic do_reset();
      step(1'b1, '0);
      step(1'b0, '0);
   endtask

   initial begin
      rst = 1'b1; src_valid = '0; src_addr = '0; src_data = '0;
      mv = '0; mrr = 0;
      for (int i = 0; i < N; i++) begin
         ma[i] = '0; md[i] = '0; st_addr[i] = '0; st_data[i] = '0;
         fcnt[i] = 0; fwait[i] = 0; fmax[i] = 0;
      end
      step(1'b1, '0);
      step(1'b1, '0);
      step(1'b0, '0);
      chk("reset_w_e", 64'(w_e), 64'(0));

      // single write, then address-0 drop
      set_src(0, 5'd5, 32'hA5A5A5A5);
      step(1'b0, 4'b0001);
      repeat (3) step(1'b0, '0);
      do_reset();
      set_src(1, 5'd0, 32'hFFFFFFFF);
      step(1'b0, 4'b0010);
      repeat (3) step(1'b0, '0);

      // all four sources at once, distinct addresses
      do_reset();
      for (int s = 0; s < N; s++) set_src(s, AW'(s + 1), 32'h1000 + s);
      step(1'b0, 4'b1111);
      repeat (4) step(1'b0, '0);

      // same-address pair from src0 and src2
      do_reset();
      set_src(0, 5'd7, 32'h11);
      set_src(2, 5'd7, 32'h22);
      step(1'b0, 4'b0101);
      repeat (3) step(1'b0, '0);

      // fairness window: every source continuously valid
      do_reset();
      for (int s = 0; s < N; s++) set_src(s, AW'(s + 1), 32'hC0DE0000 + s);
      step(1'b0, 4'b1111);
      fair_lo = cyc + 1;
      fair_hi = cyc + 8;
      repeat (8) step(1'b0, 4'b1111);
      repeat (3) step(1'b0, '0);
      for (int s = 0; s < N; s++) begin
         chk("fair_count", 64'(fcnt[s]), 64'(4));
         chk("fair_max_wait_le2", 64'(fmax[s] <= 2), 64'(1));
      end

      // reset while three holds are pending; handshakes in the reset cycle ignored
      do_reset();
      for (int s = 0; s < 3; s++) set_src(s, AW'(s + 9), 32'hBEEF0000 + s);
      step(1'b0, 4'b0111);
      step(1'b1, 4'b1111);
      step(1'b0, '0);
      chk("post_reset_w_e", 64'(w_e), 64'(0));
      chk("post_reset_ready", 64'(src_ready), 64'(4'hF));
      repeat (3) step(1'b0, '0);

      // randomized traffic with small address set to force conflicts and drops
      for (int n = 0; n < 400; n++) begin
         for (int s = 0; s < N; s++) set_src(s, AW'($urandom_range(0, 7)), $urandom);
         step(($urandom_range(0, 49) == 0), N'($urandom));
      end
      repeat (5) step(1'b0, '0);
      chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
